// File: rtl/frame_download_engine.sv
// Streams one stored frame from burst-read PSRAM into a 17-bit marker/pixel queue.
// Optional ROW_DECIMATE_EN: output rows are sampled from taller source frames.
module frame_download_engine #(
    parameter int MEMORY_BURST      = 32,
    parameter int FRAME_WIDTH       = 480,
    parameter int FRAME_HEIGHT      = 272,
    parameter int ORIG_FRAME_WIDTH  = 640,
    parameter int ORIG_FRAME_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] base_addr,
    input  logic        queue_full,
    output logic [16:0] queue_data_o,
    output logic        wr_en,
    output logic        read_rq,
    input  logic        read_ack,
    output logic [20:0] read_addr,
    output logic        mem_rd_en,
    input  logic [31:0] read_data,
    input  logic        rd_data_valid,
    output logic        download_done
);
    localparam int WORDS      = MEMORY_BURST / 4;
    localparam int CACHE_SIZE = MEMORY_BURST / 2;
    localparam int WADDR_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WCNT_W     = $clog2(WORDS + 1);
    localparam int PIX_W      = $clog2(CACHE_SIZE + 1);
    localparam int COL_W      = $clog2(FRAME_WIDTH + 1);
    localparam int ROW_W      = $clog2(FRAME_HEIGHT + 1);

    localparam logic [WCNT_W-1:0] WORDS_C = WCNT_W'(WORDS);
    localparam logic [PIX_W-1:0]  CACHE_C = PIX_W'(CACHE_SIZE);
    localparam logic [COL_W-1:0]  FW_C    = COL_W'(FRAME_WIDTH);
    localparam logic [ROW_W-1:0]  FH_C    = ROW_W'(FRAME_HEIGHT);
    localparam logic [20:0]       GAP_C   = 21'(ORIG_FRAME_WIDTH - FRAME_WIDTH);

    typedef enum logic [3:0] {
        S_IDLE, S_FRAME_START, S_ROW_START, S_ROW_LOOP, S_REQ,
        S_FILL, S_UPLOAD, S_SKIP, S_DONE
    } state_t;

    state_t              state_reg;
    logic [ROW_W-1:0]    row_reg;
    logic [COL_W-1:0]    col_reg;
    logic [PIX_W-1:0]    pix_reg;
    logic [WCNT_W-1:0]   wcnt_reg;
    logic                phase_reg;

`ifdef ROW_DECIMATE_EN
    localparam int ACC_W = $clog2(ORIG_FRAME_HEIGHT + FRAME_HEIGHT + 1);
    localparam logic [ACC_W-1:0] OH_C    = ACC_W'(ORIG_FRAME_HEIGHT);
    localparam logic [ACC_W-1:0] FHA_C   = ACC_W'(FRAME_HEIGHT);
    localparam logic [20:0]      PITCH_C = 21'(ORIG_FRAME_WIDTH);
    // acc_reg = (row*ORIG_FRAME_HEIGHT) mod FRAME_HEIGHT, kept below FRAME_HEIGHT
    logic [ACC_W-1:0] acc_reg;
`endif

    // Burst cache: 32-bit write side, 16-bit registered read side
    logic [31:0]        cache_mem [WORDS];
    logic               cache_we;
    logic [WADDR_W-1:0] cache_wr_idx;
    logic [PIX_W-1:0]   rd_pix;
    logic [WADDR_W-1:0] cache_rd_idx;
    logic [15:0]        rd_pix_reg;

    assign cache_we     = (state_reg == S_FILL) && rd_data_valid && (wcnt_reg < WORDS_C);
    assign cache_wr_idx = WADDR_W'(wcnt_reg);
    // During the increment cycle prefetch the next pixel so it is ready for the write cycle
    assign rd_pix       = (state_reg != S_UPLOAD) ? '0 :
                          (phase_reg ? pix_reg + 1'b1 : pix_reg);
    assign cache_rd_idx = WADDR_W'(rd_pix >> 1);

    always_ff @(posedge clk) begin
        if (cache_we) begin
            cache_mem[cache_wr_idx] <= read_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_pix_reg <= rd_pix[0] ? cache_mem[cache_rd_idx][31:16] : cache_mem[cache_rd_idx][15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            wr_en         <= 1'b0;
            read_rq       <= 1'b0;
            mem_rd_en     <= 1'b0;
            download_done <= 1'b0;
            queue_data_o  <= '0;
            read_addr     <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            pix_reg       <= '0;
            wcnt_reg      <= '0;
            phase_reg     <= 1'b0;
`ifdef ROW_DECIMATE_EN
            acc_reg       <= '0;
`endif
        end else begin
            wr_en         <= 1'b0;
            mem_rd_en     <= 1'b0;
            download_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    read_addr <= base_addr;
                    if (start) begin
                        row_reg   <= '0;
`ifdef ROW_DECIMATE_EN
                        acc_reg   <= '0;
`endif
                        state_reg <= S_FRAME_START;
                    end
                end
                S_FRAME_START: begin
                    if (!queue_full) begin
                        wr_en        <= 1'b1;
                        queue_data_o <= 17'h10000;
                        state_reg    <= S_ROW_START;
                    end
                end
                S_ROW_START: begin
                    if (!queue_full) begin
                        wr_en <= 1'b1;
                        if (row_reg == FH_C) begin
                            queue_data_o <= 17'h1FFFF;
                            state_reg    <= S_DONE;
                        end else begin
                            queue_data_o <= 17'h10001;
                            col_reg      <= '0;
                            state_reg    <= S_ROW_LOOP;
                        end
                    end
                end
                S_ROW_LOOP: begin
                    if (col_reg < FW_C) begin
                        read_rq   <= 1'b1;
                        state_reg <= S_REQ;
                    end else begin
                        read_addr <= read_addr + GAP_C;
                        row_reg   <= row_reg + 1'b1;
`ifdef ROW_DECIMATE_EN
                        acc_reg   <= acc_reg + OH_C - FHA_C;
                        state_reg <= S_SKIP;
`else
                        state_reg <= S_ROW_START;
`endif
                    end
                end
                S_REQ: begin
                    read_rq <= 1'b1;
                    if (read_ack) begin
                        mem_rd_en <= 1'b1;
                        wcnt_reg  <= '0;
                        state_reg <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (wcnt_reg == WORDS_C) begin
                        read_rq   <= 1'b0;
                        pix_reg   <= '0;
                        phase_reg <= 1'b0;
                        state_reg <= S_UPLOAD;
                    end else if (rd_data_valid) begin
                        wcnt_reg <= wcnt_reg + 1'b1;
                    end
                end
                S_UPLOAD: begin
                    if (phase_reg) begin
                        col_reg   <= col_reg + 1'b1;
                        pix_reg   <= pix_reg + 1'b1;
                        phase_reg <= 1'b0;
                    end else if (!queue_full) begin
                        if ((col_reg < FW_C) && (pix_reg < CACHE_C)) begin
                            wr_en        <= 1'b1;
                            queue_data_o <= {1'b0, rd_pix_reg};
                            phase_reg    <= 1'b1;
                        end else begin
                            read_addr <= read_addr + 21'(pix_reg);
                            state_reg <= S_ROW_LOOP;
                        end
                    end
                end
`ifdef ROW_DECIMATE_EN
                S_SKIP: begin
                    // Each whole FRAME_HEIGHT left in the accumulator is one skipped source row
                    if (acc_reg >= FHA_C) begin
                        acc_reg   <= acc_reg - FHA_C;
                        read_addr <= read_addr + PITCH_C;
                    end else begin
                        state_reg <= S_ROW_START;
                    end
                end
`endif
                S_DONE: begin
                    download_done <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_download_engine.sv
// Randomised bench for frame_download_engine with a PSRAM responder and a frame-level reference model.
module tb_frame_download_engine;
    localparam int FW = 20, FH = 2, OFW = 24, OH = 4, CACHE = 16, WORDS = 8;

    logic        clk = 1'b0;
    logic        reset, start, queue_full, read_ack, rd_data_valid;
    logic [20:0] base_addr, read_addr;
    logic [31:0] read_data;
    logic [16:0] queue_data_o;
    logic        wr_en, read_rq, mem_rd_en, download_done;

    frame_download_engine #(
        .MEMORY_BURST(32), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
        .ORIG_FRAME_WIDTH(OFW), .ORIG_FRAME_HEIGHT(OH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .queue_full(queue_full), .queue_data_o(queue_data_o), .wr_en(wr_en),
        .read_rq(read_rq), .read_ack(read_ack), .read_addr(read_addr),
        .mem_rd_en(mem_rd_en), .read_data(read_data), .rd_data_valid(rd_data_valid),
        .download_done(download_done)
    );

    always #5 clk = ~clk;

    int          tests_run = 0, tests_failed = 0;
    logic [31:0] seed = 32'h1234_5678;
    bit          ovr_en = 1'b0;
    logic [20:0] ovr_base = 21'h0;
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    logic [20:0] burst_q[$];
    logic [20:0] exp_b[$];
    int          done_cnt = 0, memrd_cnt = 0, ack_cnt = 0, qf_viol = 0, b2b_viol = 0;
    bit          prev_pix_wr = 1'b0;

    // Stored frame contents: a seeded hash of the pixel address, with an optional known word
    function automatic logic [15:0] pix_at(input logic [20:0] a);
        logic [31:0] h;
        if (ovr_en && a == ovr_base) return 16'hAAAA;
        if (ovr_en && a == ovr_base + 21'd1) return 16'hBBBB;
        h = ({11'd0, a} * 32'd40503) ^ seed;
        return h[15:0] ^ h[31:16];
    endfunction

    // Queue-side monitor
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (wr_en) begin
                got_q.push_back(queue_data_o);
                if (queue_full) qf_viol++;
                if (!queue_data_o[16] && prev_pix_wr) b2b_viol++;
            end
            prev_pix_wr = wr_en && !queue_data_o[16];
            if (mem_rd_en) memrd_cnt++;
            if (download_done) done_cnt++;
        end
    end

    // PSRAM read-port responder
    initial begin : mem_responder
        int          rstate, delay, word_i;
        logic [20:0] cur_addr, a;
        rstate = 0; delay = 0; word_i = 0; cur_addr = '0;
        read_ack = 1'b0; rd_data_valid = 1'b0; read_data = '0;
        forever begin
            @(negedge clk);
            read_ack = 1'b0;
            rd_data_valid = 1'b0;
            if (reset) begin
                rstate = 0;
            end else begin
                case (rstate)
                    0: if (read_rq) begin delay = $urandom_range(0, 2); rstate = 1; end
                    1: if (delay == 0) begin
                           read_ack = 1'b1; cur_addr = read_addr;
                           burst_q.push_back(read_addr); ack_cnt++; rstate = 2;
                       end else delay--;
                    2: if (mem_rd_en) begin word_i = 0; rstate = 3; end
                    3: if ($urandom_range(0, 3) != 0) begin
                           a = cur_addr + 21'(2 * word_i);
                           read_data = {pix_at(a + 21'd1), pix_at(a)};
                           rd_data_valid = 1'b1;
                           word_i++;
                           if (word_i == WORDS) rstate = 4;
                       end
                    4: if (read_rq) begin
                           read_data = 32'hDEAD_BEEF; rd_data_valid = 1'b1;
                       end else rstate = 0;
                    default: rstate = 0;
                endcase
            end
        end
    end

    task automatic build_expected(input logic [20:0] base);
        int src;
        logic [20:0] rowbase;
        exp_q.delete(); exp_b.delete();
        exp_q.push_back(17'h10000);
        for (int r = 0; r < FH; r++) begin
`ifdef ROW_DECIMATE_EN
            src = (r * OH) / FH;
`else
            src = r;
`endif
            rowbase = base + 21'(src * OFW);
            exp_q.push_back(17'h10001);
            for (int c = 0; c < FW; c++) exp_q.push_back({1'b0, pix_at(rowbase + 21'(c))});
            for (int b = 0; b * CACHE < FW; b++) exp_b.push_back(rowbase + 21'(b * CACHE));
        end
        exp_q.push_back(17'h1FFFF);
    endtask

    // qf_mode: 0 never full, 1 one 10-cycle stall mid-upload, 2 random backpressure
    task automatic run_frame(input logic [20:0] base, input int qf_mode, input bit extra_start, input string name);
        int  cyc, stall_left, n;
        bit  stalled;
        got_q.delete(); burst_q.delete();
        done_cnt = 0; memrd_cnt = 0; ack_cnt = 0; qf_viol = 0; b2b_viol = 0;
        build_expected(base);
        @(negedge clk);
        base_addr = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; stall_left = 0; stalled = 1'b0;
        while (done_cnt == 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (qf_mode == 1) begin
                if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) queue_full = 1'b0;
                end else if (!stalled && got_q.size() >= 8) begin
                    queue_full = 1'b1; stall_left = 10; stalled = 1'b1;
                end
            end else if (qf_mode == 2) begin
                queue_full = ($urandom_range(0, 9) < 3);
            end else begin
                queue_full = 1'b0;
            end
            start = (extra_start && cyc == 40);
        end
        start = 1'b0;
        queue_full = 1'b0;
        tests_run++;
        if (done_cnt == 0) begin
            tests_failed++;
            $display("FAIL %s timeout: download_done not seen after %0d cycles", name, cyc);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end
        tests_run++;
        if (got_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s queue_len: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s queue[%0d]: got %05h expected %05h", name, i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (burst_q.size() !== exp_b.size()) begin
            tests_failed++;
            $display("FAIL %s burst_count: got %0d expected %0d", name, burst_q.size(), exp_b.size());
        end
        n = (burst_q.size() < exp_b.size()) ? burst_q.size() : exp_b.size();
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (burst_q[i] !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL %s burst_addr[%0d]: got %06h expected %06h", name, i, burst_q[i], exp_b[i]);
            end
        end
        tests_run++;
        if (memrd_cnt !== ack_cnt) begin
            tests_failed++;
            $display("FAIL %s mem_rd_en_pulses: got %0d expected %0d", name, memrd_cnt, ack_cnt);
        end
        tests_run++;
        if (qf_viol !== 0) begin
            tests_failed++;
            $display("FAIL %s wr_en_while_full: got %0d expected 0", name, qf_viol);
        end
        tests_run++;
        if (b2b_viol !== 0) begin
            tests_failed++;
            $display("FAIL %s pixel_spacing: got %0d back-to-back writes expected 0", name, b2b_viol);
        end
        $display("[TB] frame %s base=%06h words=%0d bursts=%0d", name, base, got_q.size(), burst_q.size());
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; queue_full = 1'b0; base_addr = 21'h1ABCD;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({wr_en, read_rq, mem_rd_en, download_done} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b expected 0000", {wr_en, read_rq, mem_rd_en, download_done});
        end
        tests_run++;
        if (queue_data_o !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_queue_data: got %05h expected 00000", queue_data_o);
        end
        tests_run++;
        if (read_addr !== 21'h0) begin
            tests_failed++;
            $display("FAIL reset_read_addr: got %06h expected 000000", read_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (read_addr !== 21'h1ABCD) begin
            tests_failed++;
            $display("FAIL idle_track_addr: got %06h expected 01abcd", read_addr);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_pixel_order();
        ovr_en = 1'b1; ovr_base = 21'h100;
        run_frame(21'h100, 0, 1'b0, "pixel_order");
        tests_run++;
        if (got_q.size() < 4 || got_q[2] !== 17'h0AAAA || got_q[3] !== 17'h0BBBB) begin
            tests_failed++;
            $display("FAIL pixel_order: got %05h %05h expected 0aaaa 0bbbb",
                     (got_q.size() > 2) ? got_q[2] : 17'h0, (got_q.size() > 3) ? got_q[3] : 17'h0);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        bit seen = 1'b0;
        @(negedge clk);
        base_addr = 21'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (mem_rd_en) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL reset_fill_reach: got no mem_rd_en expected one within 500 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({wr_en, read_rq, mem_rd_en, download_done} !== 4'b0 || queue_data_o !== 17'h0 || read_addr !== 21'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_fill: got strobes=%b data=%05h addr=%06h expected all 0",
                     {wr_en, read_rq, mem_rd_en, download_done}, queue_data_o, read_addr);
        end
        reset = 1'b0;
        $display("[TB] reset mid-fill applied");
        run_frame(21'h100, 0, 1'b0, "after_reset");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        seed = $urandom;
        run_frame(21'h100, 0, 1'b0, "basic");
        test_pixel_order();
        seed = $urandom;
        run_frame(21'($urandom), 1, 1'b0, "stall10");
        test_reset_mid_fill();
        for (int i = 0; i < 3; i++) begin
            seed = $urandom;
            run_frame(21'($urandom), 2, (i == 1), "random");
        end
        run_frame(21'h1FFFF0, 2, 1'b0, "wrap");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
